freq_meter: RTL and testbench

Gated edge-counting frequency meter. It counts rising edges of an asynchronous input `sig_in` over a gate window of exactly `GATE_CYCLES` periods of `clk_in`, then publishes the count with a one-cycle `valid` strobe. It is the measuring counterpart to the team's clock dividers: it checks divided clocks on hardware and reports the frequency of external signals. It sits in the `clk_in` domain, and `sig_in` may come from any source.

---
 rtl/freq_meter.sv | 156 +++++++++++++++
 tb/tb_freq_meter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated edge-counting frequency meter.
// Counts synchronised rising edges of sig_in over a window of GATE_CYCLES clk_in cycles.
module freq_meter #(
  parameter int GATE_CYCLES = 100_000,
  parameter int COUNT_WIDTH = 32,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   sig_in,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   valid,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]          GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] EDGE_MAX  = {COUNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    s1_r;
  logic                    s2_r;
  logic                    s3_r;
  logic                    rise_s;
  logic                    last_s;
  logic [GW-1:0]           gate_cnt_r;
  logic [COUNT_WIDTH-1:0]  edge_cnt_r;
  logic                    ovf_acc_r;
  logic [COUNT_WIDTH-1:0]  edge_nxt_s;
  logic                    ovf_nxt_s;
  logic [COUNT_WIDTH-1:0]  count_r;
  logic                    overflow_r;
  logic                    valid_r;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                     input logic inc);
    if (inc && (v != EDGE_MAX)) begin
      return v + COUNT_WIDTH'(1'b1);
    end else begin
      return v;
    end
  endfunction

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_s     = s2_r & ~s3_r;
  assign last_s     = (state_r == ST_GATE) && (gate_cnt_r == GATE_LAST);
  assign edge_nxt_s = sat_inc(edge_cnt_r, rise_s);
  assign ovf_nxt_s  = ovf_acc_r | (rise_s & (edge_cnt_r == EDGE_MAX));

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; abort wins over window completion
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_GATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (last_s && !CONTINUOUS) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GATE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: busy is a direct decode of the state flop
  always_comb begin
    busy = (state_r == ST_GATE);
  end

  // Gate/edge counters and published result
  always_ff @(posedge clk_in) begin
    if (reset) begin
      gate_cnt_r <= {GW{1'b0}};
      edge_cnt_r <= {COUNT_WIDTH{1'b0}};
      ovf_acc_r  <= 1'b0;
      count_r    <= {COUNT_WIDTH{1'b0}};
      overflow_r <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            gate_cnt_r <= {GW{1'b0}};
            edge_cnt_r <= {COUNT_WIDTH{1'b0}};
            ovf_acc_r  <= 1'b0;
          end
        end
        ST_GATE: begin
          if (abort) begin
            gate_cnt_r <= {GW{1'b0}};
          end else if (last_s) begin
            // The boundary-cycle rise belongs to the closing window only
            count_r    <= edge_nxt_s;
            overflow_r <= ovf_nxt_s;
            valid_r    <= 1'b1;
            gate_cnt_r <= {GW{1'b0}};
            edge_cnt_r <= {COUNT_WIDTH{1'b0}};
            ovf_acc_r  <= 1'b0;
          end else begin
            gate_cnt_r <= gate_cnt_r + GW'(1'b1);
            edge_cnt_r <= edge_nxt_s;
            ovf_acc_r  <= ovf_nxt_s;
          end
        end
        default: begin
          gate_cnt_r <= {GW{1'b0}};
        end
      endcase
    end
  end

  assign valid    = valid_r;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: single-shot, narrow-counter and continuous instances.
module tb_freq_meter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        sig_in = 1'b0;
  logic        start_a, start_w, start_c;
  logic        abort;
  logic        busy_a, valid_a, overflow_a;
  logic [31:0] count_a;
  logic        busy_w, valid_w, overflow_w;
  logic [3:0]  count_w;
  logic        busy_c, valid_c, overflow_c;
  logic [31:0] count_c;

  freq_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(32), .CONTINUOUS(1'b0)) dut_a (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start_a), .abort(abort),
    .busy(busy_a), .valid(valid_a), .count(count_a), .overflow(overflow_a));

  freq_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(4), .CONTINUOUS(1'b0)) dut_w (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start_w), .abort(abort),
    .busy(busy_w), .valid(valid_w), .count(count_w), .overflow(overflow_w));

  freq_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(32), .CONTINUOUS(1'b1)) dut_c (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .start(start_c), .abort(abort),
    .busy(busy_c), .valid(valid_c), .count(count_c), .overflow(overflow_c));

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus generator state and reference edge count
  int   cyc        = 0;
  int   tick       = 0;
  int   sig_period = 0;
  int   sig_off    = 0;
  logic sig_level  = 1'b0;
  int   ref_lo     = 1;
  int   ref_hi     = 0;
  int   ref_cnt    = 0;

  function automatic logic gen_val(input int t);
    if (sig_period == 0) return sig_level;
    return (((t + sig_off) % sig_period) < (sig_period / 2));
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // sig_in changes on the falling edge; rises are tallied against the posedge index
  always @(negedge clk_in) begin
    tick   <= tick + 1;
    sig_in <= gen_val(tick);
    if (!sig_in && gen_val(tick) && (cyc >= ref_lo) && (cyc <= ref_hi))
      ref_cnt <= ref_cnt + 1;
  end

  int          sel = 0;
  logic        busy_x, valid_x, overflow_x;
  logic [31:0] count_x;
  assign busy_x     = (sel == 1) ? busy_w     : busy_a;
  assign valid_x    = (sel == 1) ? valid_w    : valid_a;
  assign overflow_x = (sel == 1) ? overflow_w : overflow_a;
  assign count_x    = (sel == 1) ? {28'd0, count_w} : count_a;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_window(input int s, input bit pulse, output int busy_cyc,
                            output int vcnt, output longint cnt, output longint ovf,
                            output longint busy_at_v);
    sel = s; busy_cyc = 0; vcnt = 0; cnt = -1; ovf = -1; busy_at_v = -1;
    @(negedge clk_in);
    if (s == 1) start_w = 1'b1; else start_a = 1'b1;
    @(negedge clk_in);
    start_a = 1'b0; start_w = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (busy_x) busy_cyc++;
      if (valid_x) begin
        vcnt++; cnt = count_x; ovf = overflow_x; busy_at_v = busy_x;
      end
      if (pulse) start_a = busy_x & i[0];
      @(negedge clk_in);
    end
    start_a = 1'b0;
  endtask

  typedef struct {
    int    sel;
    int    period;
    logic  level;
    bit    pulse;
    int    exp_count;
    logic  exp_ovf;
    string name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int     bc, vc, nv, last_v, c0;
    longint cn, ov, bv, sum;

    vecs[0] = '{0, 10, 1'b0, 1'b0, 10, 1'b0, "a_p10"};
    vecs[1] = '{0,  0, 1'b0, 1'b0,  0, 1'b0, "a_low"};
    vecs[2] = '{0,  0, 1'b1, 1'b0,  0, 1'b0, "a_high"};
    vecs[3] = '{1,  4, 1'b0, 1'b0, 15, 1'b1, "w_p4_sat"};
    vecs[4] = '{1,  0, 1'b0, 1'b0,  0, 1'b0, "w_low_after_sat"};
    vecs[5] = '{0,  5, 1'b0, 1'b0, 20, 1'b0, "a_p5"};
    vecs[6] = '{1, 10, 1'b0, 1'b0, 10, 1'b0, "w_p10"};
    vecs[7] = '{0, 10, 1'b0, 1'b1, 10, 1'b0, "a_p10_start_pulses"};

    reset = 1'b1; start_a = 1'b0; start_w = 1'b0; start_c = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_busy_a", busy_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_count_a", count_a, 0);
    check("rst_ovf_a", overflow_a, 0);
    check("rst_busy_c", busy_c, 0);
    check("rst_count_w", count_w, 0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      sig_period = vecs[k].period;
      sig_level  = vecs[k].level;
      repeat (20) @(negedge clk_in);
      run_window(vecs[k].sel, vecs[k].pulse, bc, vc, cn, ov, bv);
      check({vecs[k].name, "_busy_cycles"}, bc, 100);
      check({vecs[k].name, "_valid_pulses"}, vc, 1);
      check({vecs[k].name, "_count"}, cn, vecs[k].exp_count);
      check({vecs[k].name, "_overflow"}, ov, vecs[k].exp_ovf);
      check({vecs[k].name, "_busy_at_valid"}, bv, 0);
    end

    // Abort mid-window: no result, previous count (10) retained
    sel = 0; sig_period = 5;
    @(negedge clk_in); start_a = 1'b1;
    @(negedge clk_in); start_a = 1'b0;
    repeat (50) @(negedge clk_in);
    abort = 1'b1;
    @(negedge clk_in); abort = 1'b0;
    check("abort50_busy", busy_a, 0);
    vc = 0;
    for (int i = 0; i < 150; i++) begin
      if (valid_a) vc++;
      @(negedge clk_in);
    end
    check("abort50_no_valid", vc, 0);
    check("abort50_count_kept", count_a, 10);
    check("abort50_ovf_kept", overflow_a, 0);

    // Abort on the last gate cycle beats completion
    @(negedge clk_in); start_a = 1'b1;
    @(negedge clk_in); start_a = 1'b0;
    repeat (99) @(negedge clk_in);
    check("abort_last_busy_before", busy_a, 1);
    abort = 1'b1;
    @(negedge clk_in); abort = 1'b0;
    check("abort_last_no_valid", valid_a, 0);
    check("abort_last_busy", busy_a, 0);
    check("abort_last_count_kept", count_a, 10);

    // Reset mid-window returns every output to its reset value
    sig_period = 10;
    @(negedge clk_in); start_a = 1'b1;
    @(negedge clk_in); start_a = 1'b0;
    repeat (50) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_valid", valid_a, 0);
    check("rst_mid_count", count_a, 0);
    check("rst_mid_ovf", overflow_a, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk_in);
    run_window(0, 1'b0, bc, vc, cn, ov, bv);
    check("after_rst_busy_cycles", bc, 100);
    check("after_rst_valid_pulses", vc, 1);
    check("after_rst_count", cn, 10);

    // Continuous mode: 20 back-to-back windows, period 7, random phase
    sig_off    = int'($urandom_range(0, 6));
    sig_period = 7;
    repeat (20) @(negedge clk_in);
    c0     = cyc + 3;
    ref_lo = c0 - 1;
    ref_hi = c0 + 1998;
    for (int i = 0; i < 10 && cyc != c0; i++) @(negedge clk_in);
    check("cont_start_align", cyc, c0);
    start_c = 1'b1;
    @(negedge clk_in); start_c = 1'b0;
    nv = 0; last_v = 0; sum = 0;
    for (int i = 0; i < 2300 && nv < 20; i++) begin
      if (valid_c) begin
        if (nv == 0) check("cont_first_valid_cycle", cyc, c0 + 101);
        else         check("cont_valid_spacing", cyc - last_v, 100);
        check("cont_count_14_or_15", (count_c == 32'd14) || (count_c == 32'd15), 1);
        check("cont_overflow", overflow_c, 0);
        sum += count_c; last_v = cyc; nv++;
      end
      if (nv < 20) @(negedge clk_in);
    end
    abort = 1'b1;
    @(negedge clk_in); abort = 1'b0;
    check("cont_valid_strobes", nv, 20);
    check("cont_sum_vs_reference", sum, ref_cnt);
    check("cont_abort_busy", busy_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
